// File: rtl/rr_mux_sel_arbiter_if.sv
// Request/grant bus between the requesters and the round-robin mux-select arbiter.
interface rr_mux_sel_arbiter_if;
    logic [2:0] req;
    logic       done;
    logic [1:0] sel;
    logic [2:0] gnt;
    logic       busy;
    logic       timeout;

    modport master (output req, done, input sel, gnt, busy, timeout);
    modport slave  (input req, done, output sel, gnt, busy, timeout);
endinterface

// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit mux select for three requesters.
// Optional hold-time watchdog enabled by defining ARB_HOLD_TIMEOUT_EN.
module rr_mux_sel_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input logic                 clk,
    input logic                 reset,
    rr_mux_sel_arbiter_if.slave bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    if (MAX_HOLD < 1 || MAX_HOLD > 15 || (2 ** HOLD_W) <= MAX_HOLD) begin : g_param_check
        $error("rr_mux_sel_arbiter: illegal MAX_HOLD/HOLD_W");
    end

    function automatic logic [1:0] rot_inc(input logic [1:0] v);
        case (v)
            2'd0:    rot_inc = 2'd1;
            2'd1:    rot_inc = 2'd2;
            2'd2:    rot_inc = 2'd0;
            default: rot_inc = 2'd0;
        endcase
    endfunction

    function automatic logic req_at(input logic [2:0] r, input logic [1:0] idx);
        case (idx)
            2'd0:    req_at = r[0];
            2'd1:    req_at = r[1];
            2'd2:    req_at = r[2];
            default: req_at = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] one_hot(input logic [1:0] idx);
        case (idx)
            2'd0:    one_hot = 3'b001;
            2'd1:    one_hot = 3'b010;
            2'd2:    one_hot = 3'b100;
            default: one_hot = 3'b000;
        endcase
    endfunction

    logic [0:0] state_r, next_state_s;
    logic [1:0] last_r, next_last_s;
    logic [1:0] sel_r, next_sel_s;
    logic [2:0] gnt_r, next_gnt_s;
    logic       busy_r, next_busy_s;
    logic       timeout_r, next_timeout_s;
    logic [1:0] cand1_s, cand2_s, win_s;
    logic       win_valid_s;
    logic       owner_req_s;
    logic       expire_s;
    logic       release_s;

    // Pick the first requester after the last owner, wrapping 2 -> 0.
    always_comb begin
        cand1_s     = rot_inc(last_r);
        cand2_s     = rot_inc(cand1_s);
        win_valid_s = |bus.req;
        if (req_at(bus.req, cand1_s)) begin
            win_s = cand1_s;
        end else if (req_at(bus.req, cand2_s)) begin
            win_s = cand2_s;
        end else begin
            win_s = last_r;
        end
    end

`ifdef ARB_HOLD_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_r;

    // Hold counter: cleared while idle, counts granted cycles, saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_r <= {HOLD_W{1'b0}};
        end else if (state_r == IDLE) begin
            hold_r <= {HOLD_W{1'b0}};
        end else if (!release_s && hold_r != HOLD_W'(MAX_HOLD)) begin
            hold_r <= hold_r + {{(HOLD_W-1){1'b0}}, 1'b1};
        end else begin
            hold_r <= hold_r;
        end
    end

    assign expire_s = (hold_r == HOLD_W'(MAX_HOLD - 1)) && !bus.done && owner_req_s;
`else
    assign expire_s = 1'b0;
`endif

    assign owner_req_s = req_at(bus.req, sel_r);
    assign release_s   = bus.done || !owner_req_s || expire_s;

    // Next-state and next-output decode; sel is only ever loaded with a winner.
    always_comb begin
        next_state_s   = state_r;
        next_last_s    = last_r;
        next_sel_s     = sel_r;
        next_gnt_s     = gnt_r;
        next_busy_s    = busy_r;
        next_timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (win_valid_s) begin
                    next_state_s = GRANT;
                    next_last_s  = win_s;
                    next_sel_s   = win_s;
                    next_gnt_s   = one_hot(win_s);
                    next_busy_s  = 1'b1;
                end else begin
                    next_gnt_s  = 3'b000;
                    next_busy_s = 1'b0;
                end
            end
            GRANT: begin
                if (release_s) begin
                    next_state_s   = IDLE;
                    next_gnt_s     = 3'b000;
                    next_busy_s    = 1'b0;
                    next_timeout_s = expire_s;
                end else begin
                    next_state_s = GRANT;
                end
            end
            default: begin
                next_state_s = IDLE;
                next_gnt_s   = 3'b000;
                next_busy_s  = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            last_r    <= 2'd2;
            sel_r     <= 2'b00;
            gnt_r     <= 3'b000;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            last_r    <= next_last_s;
            sel_r     <= next_sel_s;
            gnt_r     <= next_gnt_s;
            busy_r    <= next_busy_s;
            timeout_r <= next_timeout_s;
        end
    end

    assign bus.sel     = sel_r;
    assign bus.gnt     = gnt_r;
    assign bus.busy    = busy_r;
    assign bus.timeout = timeout_r;
endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// Directed bench for rr_mux_sel_arbiter; observed word is {gnt, sel, busy, timeout}.
module tb_rr_mux_sel_arbiter;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    rr_mux_sel_arbiter_if bus ();

    rr_mux_sel_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] obs();
        return {bus.gnt, bus.sel, bus.busy, bus.timeout};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.req  = 3'b000;
        bus.done = 1'b0;
        reset    = 1'b1;
        #3;
        reset    = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] o;
        bus.req  = 3'b000;
        bus.done = 1'b0;
        reset    = 1'b0;
        #1 reset = 1'b1;
        #1;
        o = obs();
        n_checks++;
        if (o !== 7'b000_00_0_0) begin
            n_fail++;
            $display("FAIL reset_values got=%b exp=%b", o, 7'b000_00_0_0);
        end
        #9 reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 5) bus.done = 1'b1;
            else bus.done = 1'b0;
            o = obs();
            n_checks++;
            if (o !== 7'b000_00_0_0) begin
                n_fail++;
                $display("FAIL idle_stable cyc=%0d got=%b exp=%b", i, o, 7'b000_00_0_0);
            end
        end
        bus.done = 1'b0;
    endtask

    task automatic test_single_request();
        logic [6:0] o;
        bus.req = 3'b010;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) bus.done = 1'b1;
            o = obs();
            n_checks++;
            if (o !== 7'b010_01_1_0) begin
                n_fail++;
                $display("FAIL single_grant cyc=%0d got=%b exp=%b", i, o, 7'b010_01_1_0);
            end
        end
        tick();
        bus.done = 1'b0;
        bus.req  = 3'b000;
        o = obs();
        n_checks++;
        if (o !== 7'b000_01_0_0) begin
            n_fail++;
            $display("FAIL single_release got=%b exp=%b", o, 7'b000_01_0_0);
        end
        tick();
        o = obs();
        n_checks++;
        if (o !== 7'b000_01_0_0) begin
            n_fail++;
            $display("FAIL single_sel_held got=%b exp=%b", o, 7'b000_01_0_0);
        end
    endtask

    task automatic test_round_robin();
        logic [6:0] o;
        logic [6:0] exp_g;
        logic [2:0] gnt_tab [3];
        logic [1:0] sel_tab [3];
        gnt_tab = '{3'b001, 3'b010, 3'b100};
        sel_tab = '{2'b00, 2'b01, 2'b10};
        apply_reset();
        tick();
        bus.req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_g = {gnt_tab[k % 3], sel_tab[k % 3], 1'b1, 1'b0};
            for (int c = 0; c < 3; c++) begin
                tick();
                o = obs();
                n_checks++;
                if (o !== exp_g || bus.sel === 2'b11) begin
                    n_fail++;
                    $display("FAIL rr_grant k=%0d cyc=%0d got=%b exp=%b", k, c, o, exp_g);
                end
            end
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            o = obs();
            n_checks++;
            if (o !== {3'b000, sel_tab[k % 3], 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL rr_gap k=%0d got=%b exp=%b", k, o, {3'b000, sel_tab[k % 3], 2'b00});
            end
        end
        bus.req = 3'b000;
        tick();
    endtask

    task automatic test_owner_drop();
        logic [6:0] o;
        apply_reset();
        tick();
        bus.req = 3'b100;
        tick();
        bus.req = 3'b101;
        for (int i = 0; i < 3; i++) begin
            o = obs();
            n_checks++;
            if (o !== 7'b100_10_1_0) begin
                n_fail++;
                $display("FAIL drop_hold cyc=%0d got=%b exp=%b", i, o, 7'b100_10_1_0);
            end
            tick();
        end
        bus.req = 3'b001;
        tick();
        o = obs();
        n_checks++;
        if (o !== 7'b000_10_0_0) begin
            n_fail++;
            $display("FAIL drop_release got=%b exp=%b", o, 7'b000_10_0_0);
        end
        tick();
        o = obs();
        n_checks++;
        if (o !== 7'b001_00_1_0) begin
            n_fail++;
            $display("FAIL drop_regrant got=%b exp=%b", o, 7'b001_00_1_0);
        end
        bus.req = 3'b000;
        tick();
    endtask

    task automatic test_watchdog();
        logic [6:0] o;
        apply_reset();
        tick();
        bus.req = 3'b001;
`ifdef ARB_HOLD_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            tick();
            o = obs();
            n_checks++;
            if (o !== 7'b001_00_1_0) begin
                n_fail++;
                $display("FAIL wd_hold cyc=%0d got=%b exp=%b", i, o, 7'b001_00_1_0);
            end
        end
        tick();
        o = obs();
        n_checks++;
        if (o !== 7'b000_00_0_1) begin
            n_fail++;
            $display("FAIL wd_timeout got=%b exp=%b", o, 7'b000_00_0_1);
        end
        tick();
        o = obs();
        n_checks++;
        if (o !== 7'b001_00_1_0) begin
            n_fail++;
            $display("FAIL wd_regrant got=%b exp=%b", o, 7'b001_00_1_0);
        end
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            o = obs();
            n_checks++;
            if (o !== 7'b001_00_1_0) begin
                n_fail++;
                $display("FAIL nowd_hold cyc=%0d got=%b exp=%b", i, o, 7'b001_00_1_0);
            end
        end
`endif
        bus.req = 3'b000;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        logic [6:0] o;
        apply_reset();
        tick();
        bus.req = 3'b010;
        tick();
        o = obs();
        n_checks++;
        if (o !== 7'b010_01_1_0) begin
            n_fail++;
            $display("FAIL mid_pre got=%b exp=%b", o, 7'b010_01_1_0);
        end
        #2 reset = 1'b1;
        #1;
        o = obs();
        n_checks++;
        if (o !== 7'b000_00_0_0) begin
            n_fail++;
            $display("FAIL mid_reset got=%b exp=%b", o, 7'b000_00_0_0);
        end
        bus.req = 3'b111;
        #1 reset = 1'b0;
        tick();
        o = obs();
        n_checks++;
        if (o !== 7'b001_00_1_0) begin
            n_fail++;
            $display("FAIL mid_first_grant got=%b exp=%b", o, 7'b001_00_1_0);
        end
        bus.req = 3'b000;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_request();
        test_round_robin();
        test_owner_drop();
        test_watchdog();
        test_reset_mid_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
